// File: rtl/cordic_iter_ctrl.sv
// -----------------------------------------------------------------------------
// cordic_iter_ctrl
//   Drives one external CORDIC slice iteratively: one micro-rotation per clock,
//   with the slice's registered outputs fed back as its next inputs. Operands
//   enter over a valid/ready handshake; the final slice output is captured into
//   a valid/ready result register.
//
// Ports
//   clk_i, rst_i            clock, synchronous active-high reset
//   s_valid_i / s_ready_o   operand handshake (ready only while idle)
//   x_i, y_i, z_i           signed operands
//   m_valid_o / m_ready_i   result handshake
//   x_o, y_o, z_o           signed result registers
//   busy_o                  operation in progress (state != IDLE)
//   slc_x/y/z_o             slice X/Y/Z inputs
//   slc_shift_o             slice shift value (iteration index)
//   slc_angle_o             slice elementary rotation angle
//   slc_x/y/z_i             slice registered X/Y/Z outputs
// -----------------------------------------------------------------------------
module cordic_iter_ctrl #(
   parameter int N_INT          = 0,
   parameter int N_FRAC         = -7,
   parameter int ITERATIONS     = 8,
   parameter int SHIFT_BITWIDTH = 8,
   localparam int BITWIDTH      = N_INT - N_FRAC + 1
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       s_valid_i,
   output logic                       s_ready_o,
   input  logic signed [BITWIDTH-1:0] x_i,
   input  logic signed [BITWIDTH-1:0] y_i,
   input  logic signed [BITWIDTH-1:0] z_i,
   output logic                       m_valid_o,
   input  logic                       m_ready_i,
   output logic signed [BITWIDTH-1:0] x_o,
   output logic signed [BITWIDTH-1:0] y_o,
   output logic signed [BITWIDTH-1:0] z_o,
   output logic                       busy_o,
   output logic signed [BITWIDTH-1:0] slc_x_o,
   output logic signed [BITWIDTH-1:0] slc_y_o,
   output logic signed [BITWIDTH-1:0] slc_z_o,
   output logic [SHIFT_BITWIDTH-1:0]  slc_shift_o,
   output logic [BITWIDTH-1:0]        slc_angle_o,
   input  logic signed [BITWIDTH-1:0] slc_x_i,
   input  logic signed [BITWIDTH-1:0] slc_y_i,
   input  logic signed [BITWIDTH-1:0] slc_z_i
);

   localparam int CNT_W = (SHIFT_BITWIDTH > 5) ? SHIFT_BITWIDTH : 5;
   localparam int ANG_S = 15 + N_FRAC;

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_CAPT, ST_OUT} state_t;

   // atan(2^-k) in 2^-15 units, rescaled to the slice's fixed-point format
   // with round-half-up when dropping bits.
   function automatic logic [BITWIDTH-1:0] angle_entry(input int k);
      int t;
      int r;
      case (k)
         0:  t = 25736;
         1:  t = 15193;
         2:  t = 8027;
         3:  t = 4075;
         4:  t = 2045;
         5:  t = 1024;
         6:  t = 512;
         7:  t = 256;
         8:  t = 128;
         9:  t = 64;
         10: t = 32;
         11: t = 16;
         12: t = 8;
         13: t = 4;
         14: t = 2;
         default: t = 1;
      endcase
      if (ANG_S <= 0) r = t <<< (-ANG_S);
      else            r = (t + (1 <<< (ANG_S - 1))) >>> ANG_S;
      return r[BITWIDTH-1:0];
   endfunction

   logic [BITWIDTH-1:0] ang_tbl [16];

   for (genvar g = 0; g < 16; g++) begin : g_ang
      assign ang_tbl[g] = angle_entry(g);
   end

   state_t                     state_q;
   logic [CNT_W-1:0]           cnt_q;
   logic signed [BITWIDTH-1:0] x_q, y_q, z_q;
   logic                       m_valid_q;
   logic [3:0]                 ang_idx;

   assign s_ready_o = (state_q == ST_IDLE);
   assign busy_o    = (state_q != ST_IDLE);
   assign m_valid_o = m_valid_q;
   assign x_o       = x_q;
   assign y_o       = y_q;
   assign z_o       = z_q;

   // Iteration 0 is issued straight from the operand inputs while idle, so
   // the counter only has to cover iterations 1..ITERATIONS-1.
   assign ang_idx = (state_q == ST_IDLE) ? 4'd0 : cnt_q[3:0];

   always_comb begin
      slc_x_o     = slc_x_i;
      slc_y_o     = slc_y_i;
      slc_z_o     = slc_z_i;
      slc_shift_o = SHIFT_BITWIDTH'(cnt_q);
      if (state_q == ST_IDLE) begin
         slc_x_o     = x_i;
         slc_y_o     = y_i;
         slc_z_o     = z_i;
         slc_shift_o = '0;
      end
      slc_angle_o = ang_tbl[ang_idx];
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         x_q       <= '0;
         y_q       <= '0;
         z_q       <= '0;
         m_valid_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (s_valid_i) begin
                  cnt_q   <= CNT_W'(1);
                  state_q <= (ITERATIONS == 1) ? ST_CAPT : ST_RUN;
               end
            end
            ST_RUN: begin
               cnt_q <= cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(ITERATIONS - 1)) state_q <= ST_CAPT;
            end
            ST_CAPT: begin
               // Slice now holds the result of the last iteration; the update
               // it performs on this same edge is discarded.
               x_q       <= slc_x_i;
               y_q       <= slc_y_i;
               z_q       <= slc_z_i;
               m_valid_q <= 1'b1;
               state_q   <= ST_OUT;
            end
            ST_OUT: begin
               if (m_ready_i) begin
                  m_valid_q <= 1'b0;
                  state_q   <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cordic_iter_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cordic_iter_ctrl
//   Two controllers (ITERATIONS=8 and ITERATIONS=1), each closing the loop
//   through a behavioural circular/rotation-mode slice with saturation.
// -----------------------------------------------------------------------------
module tb_cordic_iter_ctrl;

   typedef struct packed {
      logic signed [7:0] x;
      logic signed [7:0] y;
      logic signed [7:0] z;
   } xyz_t;

   typedef struct {
      int x, y, z;
      int ex, ey, ez;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // ITERATIONS=8 instance
   logic              s_valid = 1'b0, m_ready = 1'b0;
   logic              s_ready, m_valid, busy;
   logic signed [7:0] xin = '0, yin = '0, zin = '0;
   logic signed [7:0] xo, yo, zo, sxo, syo, szo;
   logic signed [7:0] sxi, syi, szi;
   logic [7:0]        shift, angle;

   // ITERATIONS=1 instance
   logic              s_valid1 = 1'b0, m_ready1 = 1'b0;
   logic              s_ready1, m_valid1, busy1;
   logic signed [7:0] xin1 = '0, yin1 = '0, zin1 = '0;
   logic signed [7:0] xo1, yo1, zo1, sxo1, syo1, szo1;
   logic signed [7:0] sxi1, syi1, szi1;
   logic [7:0]        shift1, angle1;

   int   errors = 0;
   int   checks = 0;
   xyz_t exp_q[$];
   int   ang_ref [8] = '{101, 59, 31, 16, 8, 4, 2, 1};
   vec_t tbl [3];

   cordic_iter_ctrl #(.N_INT(0), .N_FRAC(-7), .ITERATIONS(8), .SHIFT_BITWIDTH(8)) u_dut (
      .clk_i(clk), .rst_i(rst),
      .s_valid_i(s_valid), .s_ready_o(s_ready),
      .x_i(xin), .y_i(yin), .z_i(zin),
      .m_valid_o(m_valid), .m_ready_i(m_ready),
      .x_o(xo), .y_o(yo), .z_o(zo),
      .busy_o(busy),
      .slc_x_o(sxo), .slc_y_o(syo), .slc_z_o(szo),
      .slc_shift_o(shift), .slc_angle_o(angle),
      .slc_x_i(sxi), .slc_y_i(syi), .slc_z_i(szi)
   );

   cordic_iter_ctrl #(.N_INT(0), .N_FRAC(-7), .ITERATIONS(1), .SHIFT_BITWIDTH(8)) u_dut1 (
      .clk_i(clk), .rst_i(rst),
      .s_valid_i(s_valid1), .s_ready_o(s_ready1),
      .x_i(xin1), .y_i(yin1), .z_i(zin1),
      .m_valid_o(m_valid1), .m_ready_i(m_ready1),
      .x_o(xo1), .y_o(yo1), .z_o(zo1),
      .busy_o(busy1),
      .slc_x_o(sxo1), .slc_y_o(syo1), .slc_z_o(szo1),
      .slc_shift_o(shift1), .slc_angle_o(angle1),
      .slc_x_i(sxi1), .slc_y_i(syi1), .slc_z_i(szi1)
   );

   function automatic logic signed [7:0] sat8(input int v);
      if (v > 127)  return 8'sd127;
      if (v < -128) return -8'sd128;
      return 8'(v);
   endfunction

   // One rotation-mode micro-rotation: direction follows the sign of z.
   function automatic xyz_t slice_step(input xyz_t a, input int sh, input int ang);
      int x, y, z, xs, ys;
      xyz_t r;
      x  = a.x;
      y  = a.y;
      z  = a.z;
      xs = x >>> sh;
      ys = y >>> sh;
      if (z >= 0) begin
         r.x = sat8(x - ys); r.y = sat8(y + xs); r.z = sat8(z - ang);
      end else begin
         r.x = sat8(x + ys); r.y = sat8(y - xs); r.z = sat8(z + ang);
      end
      return r;
   endfunction

   function automatic xyz_t ref_op(input int x, input int y, input int z);
      xyz_t a;
      a.x = 8'(x); a.y = 8'(y); a.z = 8'(z);
      for (int k = 0; k < 8; k++) a = slice_step(a, k, ang_ref[k]);
      return a;
   endfunction

   // Behavioural slices with registered outputs
   xyz_t nxt, nxt1;
   assign nxt  = slice_step(xyz_t'({sxo, syo, szo}), int'(shift), int'(angle));
   assign nxt1 = slice_step(xyz_t'({sxo1, syo1, szo1}), int'(shift1), int'(angle1));

   always_ff @(posedge clk) begin
      if (rst) begin
         sxi <= '0; syi <= '0; szi <= '0;
         sxi1 <= '0; syi1 <= '0; szi1 <= '0;
      end else begin
         sxi <= nxt.x;  syi <= nxt.y;  szi <= nxt.z;
         sxi1 <= nxt1.x; syi1 <= nxt1.y; szi1 <= nxt1.z;
      end
   end

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Waits for idle, then presents operands for one accepting edge.
   task automatic start_op(input int ax, input int ay, input int az);
      bit ok;
      ok = 0;
      for (int i = 0; i < 50; i++) begin
         if (s_ready) begin ok = 1; break; end
         @(posedge clk); #1;
      end
      if (!ok) chk("idle_timeout", 0, 1);
      @(negedge clk);
      s_valid = 1'b1;
      xin = 8'(ax); yin = 8'(ay); zin = 8'(az);
      @(posedge clk); #1;
      s_valid = 1'b0;
   endtask

   task automatic wait_mvalid(input string nm, output bit ok);
      ok = 0;
      for (int i = 0; i < 40; i++) begin
         if (m_valid) begin ok = 1; break; end
         @(posedge clk); #1;
      end
      if (!ok) chk({nm, "_timeout"}, 0, 1);
   endtask

   task automatic check_result(input string nm);
      xyz_t e;
      if (exp_q.size() == 0) begin
         chk({nm, "_sb_empty"}, 0, 1);
         return;
      end
      e = exp_q.pop_front();
      chk({nm, "_x"}, int'(xo), int'(e.x));
      chk({nm, "_y"}, int'(yo), int'(e.y));
      chk({nm, "_z"}, int'(zo), int'(e.z));
   endtask

   task automatic release_out();
      m_ready = 1'b1;
      @(posedge clk); #1;
      m_ready = 1'b0;
   endtask

   task automatic run_op(input string nm, input int ax, input int ay, input int az, input xyz_t e);
      bit ok;
      exp_q.push_back(e);
      start_op(ax, ay, az);
      wait_mvalid(nm, ok);
      if (ok) check_result(nm);
      else if (exp_q.size() != 0) void'(exp_q.pop_front());
      release_out();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      xyz_t e;
      bit   ok;
      bit   stable;

      tbl[0] = '{x: 78, y: 0, z: 0,  ex: 127, ey: 0,  ez: 0};
      tbl[1] = '{x: 78, y: 0, z: 67, ex: 113, ey: 64, ez: -1};
      tbl[2] = '{x: 0,  y: 0, z: 0,  ex: 0,   ey: 0,  ez: 0};

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_s_ready", int'(s_ready), 1);
      chk("rst_busy", int'(busy), 0);
      chk("rst_m_valid", int'(m_valid), 0);
      chk("rst_x_o", int'(xo), 0);
      chk("rst_y_o", int'(yo), 0);
      chk("rst_z_o", int'(zo), 0);
      chk("rst1_s_ready", int'(s_ready1), 1);
      chk("rst1_m_valid", int'(m_valid1), 0);

      // Angle/shift sequence and latency, using table entry 0
      @(negedge clk);
      s_valid = 1'b1;
      xin = 8'(tbl[0].x); yin = 8'(tbl[0].y); zin = 8'(tbl[0].z);
      e.x = 8'(tbl[0].ex); e.y = 8'(tbl[0].ey); e.z = 8'(tbl[0].ez);
      exp_q.push_back(e);
      #1;
      chk("seq_angle0", int'(angle), ang_ref[0]);
      chk("seq_shift0", int'(shift), 0);
      @(posedge clk); #1;
      s_valid = 1'b0;
      for (int k = 1; k < 8; k++) begin
         chk($sformatf("seq_angle%0d", k), int'(angle), ang_ref[k]);
         chk($sformatf("seq_shift%0d", k), int'(shift), k);
         chk($sformatf("seq_early_valid%0d", k), int'(m_valid), 0);
         @(posedge clk); #1;
      end
      chk("seq_valid_edge8", int'(m_valid), 0);
      @(posedge clk); #1;
      chk("seq_valid_edge9", int'(m_valid), 1);
      check_result("seq");
      release_out();

      // Table-driven vectors
      for (int i = 1; i < 3; i++) begin
         e.x = 8'(tbl[i].ex); e.y = 8'(tbl[i].ey); e.z = 8'(tbl[i].ez);
         run_op($sformatf("tbl%0d", i), tbl[i].x, tbl[i].y, tbl[i].z, e);
      end

      // Random operands against the reference model
      for (int i = 0; i < 4; i++) begin
         int rx, ry, rz;
         rx = int'($urandom_range(120)) - 60;
         ry = int'($urandom_range(120)) - 60;
         rz = int'($urandom_range(200)) - 100;
         run_op($sformatf("rnd%0d", i), rx, ry, rz, ref_op(rx, ry, rz));
      end

      // Backpressure: result held, new operands ignored
      e.x = 8'(tbl[1].ex); e.y = 8'(tbl[1].ey); e.z = 8'(tbl[1].ez);
      exp_q.push_back(e);
      start_op(tbl[1].x, tbl[1].y, tbl[1].z);
      wait_mvalid("bp", ok);
      if (ok) check_result("bp");
      else if (exp_q.size() != 0) void'(exp_q.pop_front());
      stable = 1;
      for (int i = 0; i < 20; i++) begin
         if (i == 5) begin
            s_valid = 1'b1; xin = 8'sd5; yin = 8'sd5; zin = 8'sd5;
         end
         if (i == 6) s_valid = 1'b0;
         @(posedge clk); #1;
         if (xo !== e.x || yo !== e.y || zo !== e.z || m_valid !== 1'b1 || s_ready !== 1'b0)
            stable = 0;
      end
      chk("bp_stable", int'(stable), 1);
      chk("bp_busy", int'(busy), 1);
      release_out();
      chk("bp_s_ready_after", int'(s_ready), 1);
      chk("bp_m_valid_after", int'(m_valid), 0);

      // Reset during iteration 4
      start_op(40, 20, 10);
      repeat (3) begin @(posedge clk); #1; end
      chk("mid_shift", int'(shift), 4);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("mid_rst_s_ready", int'(s_ready), 1);
      chk("mid_rst_busy", int'(busy), 0);
      chk("mid_rst_m_valid", int'(m_valid), 0);
      chk("mid_rst_x_o", int'(xo), 0);
      chk("mid_rst_y_o", int'(yo), 0);
      chk("mid_rst_z_o", int'(zo), 0);
      e.x = 8'(tbl[1].ex); e.y = 8'(tbl[1].ey); e.z = 8'(tbl[1].ez);
      run_op("post_rst", tbl[1].x, tbl[1].y, tbl[1].z, e);

      // Single-iteration build: one step with shift 0 and angle 101
      @(negedge clk);
      s_valid1 = 1'b1; xin1 = 8'sd64; yin1 = 8'sd0; zin1 = 8'sd10;
      #1;
      chk("it1_angle", int'(angle1), 101);
      chk("it1_shift", int'(shift1), 0);
      @(posedge clk); #1;
      s_valid1 = 1'b0;
      chk("it1_valid_edge1", int'(m_valid1), 0);
      chk("it1_busy", int'(busy1), 1);
      @(posedge clk); #1;
      chk("it1_valid_edge2", int'(m_valid1), 1);
      chk("it1_x", int'(xo1), 64);
      chk("it1_y", int'(yo1), 64);
      chk("it1_z", int'(zo1), -91);
      m_ready1 = 1'b1;
      @(posedge clk); #1;
      m_ready1 = 1'b0;
      chk("it1_s_ready_after", int'(s_ready1), 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
